// File: rtl/io_pkg.sv
// Shared encodings for the BLAKE2 host ingress: command and loopback codes,
// control FSM states and the block-flag command test.
package io_pkg;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_LAST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    LB_NONE    = 2'd0,
    LB_DATA    = 2'd1,
    LB_CMD     = 2'd2,
    LB_CMD_ALT = 2'd3
  } loopback_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // START and LAST carry block-boundary meaning; only legal on a block's first beat
  function automatic logic is_flag_cmd(input logic [1:0] cmd);
    return (cmd == CMD_START) || (cmd == CMD_LAST);
  endfunction

endpackage

// File: rtl/io_skid_fifo.sv
// Two-entry valid/ready buffer: the head register feeds the consumer directly,
// the tail register absorbs one extra entry while the consumer stalls.
module io_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d, cnt_mid;
  logic         do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;
  assign head_o  = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_mid = cnt_q - {1'b0, do_pop};
    if (do_pop) begin
      head_d = tail_q;
      tail_d = '0;
    end
    // a push lands in whichever slot is first free after this cycle's pop
    if (do_push) begin
      if (cnt_mid == 2'd0) head_d = push_data_i;
      else                 tail_d = push_data_i;
    end
    cnt_d = cnt_mid + {1'b0, do_push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/io_block_ingress.sv
// Host ingress for the BLAKE2 core: valid/ready beat intake, config capture,
// block indexing/flagging, skid buffering towards the core and loopback return.
module io_block_ingress
  import io_pkg::*;
#(
  parameter  int BEAT_W      = 8,
  parameter  int BLOCK_BYTES = 64,
  parameter  int LL_W        = 64,
  parameter  int KW          = 6,
  localparam int BEATS       = BLOCK_BYTES * 8 / BEAT_W,
  localparam int IDX_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        cmd_i,
  input  logic [BEAT_W-1:0] data_i,
  input  logic [1:0]        loopback_mode_i,
  output logic [KW-1:0]     kk_o,
  output logic [KW-1:0]     nn_o,
  output logic [LL_W-1:0]   ll_o,
  output logic              data_v_o,
  input  logic              data_ready_i,
  output logic [BEAT_W-1:0] data_o,
  output logic [IDX_W-1:0]  data_idx_o,
  output logic              block_first_o,
  output logic              block_last_o,
  output logic [LL_W-1:0]   byte_cnt_o,
  output logic              err_o,
  input  logic              ready_v_i,
  input  logic              hash_v_i,
  input  logic [BEAT_W-1:0] hash_i,
  output logic              ready_v_o,
  output logic              hash_v_o,
  output logic [BEAT_W-1:0] hash_o
);

  localparam int LL_BEATS   = LL_W / BEAT_W;
  localparam int CFG_LAST   = LL_BEATS + 2;
  localparam int CFG_W      = $clog2(CFG_LAST + 1);
  localparam int BEAT_BYTES = BEAT_W / 8;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              first;
    logic              last;
  } entry_t;

  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_cnt_q, cfg_cnt_d, cfg_idx;
  logic [IDX_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [LL_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LL_W-1:0]  ll_q, ll_d;
  logic [KW-1:0]    kk_q, kk_d, nn_q, nn_d;
  logic             err_q, err_d;
  logic             first_q, first_d, last_q, last_d;
  logic             acc, push, fifo_full, fifo_empty;
  entry_t           push_entry, head;
  logic [7:0]       echo;

  // CONF waits for a drained buffer so config never overtakes queued data
  assign ready_o = en_q & ((cmd_i == CMD_CONF) ? fifo_empty : ~fifo_full);
  assign acc     = en_q & valid_i & ready_o;

  always_comb begin
    en_d       = en_i;
    mode_d     = en_q ? loopback_mode_i : mode_q;
    state_d    = state_q;
    cfg_cnt_d  = cfg_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ll_d       = ll_q;
    kk_d       = kk_q;
    nn_d       = nn_q;
    err_d      = err_q;
    first_d    = first_q;
    last_d     = last_q;
    cfg_idx    = cfg_cnt_q;
    push       = 1'b0;
    if (acc) begin
      if (cmd_i == CMD_CONF) begin
        if (state_q != ST_CFG) begin
          cfg_idx    = '0;
          blk_cnt_d  = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
        state_d = ST_CFG;
        if (cfg_idx == CFG_W'(0))                 kk_d = data_i[KW-1:0];
        else if (cfg_idx == CFG_W'(1))            nn_d = data_i[KW-1:0];
        else if (cfg_idx <= CFG_W'(LL_BEATS + 1)) ll_d = {data_i, ll_q[LL_W-1:BEAT_W]};
        else                                      err_d = 1'b1;
        cfg_cnt_d = (cfg_idx == CFG_W'(CFG_LAST)) ? cfg_idx : cfg_idx + CFG_W'(1);
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        state_d = ST_DATA;
        push    = 1'b1;
        if (blk_cnt_q == '0) begin
          first_d = (cmd_i == CMD_START);
          last_d  = (cmd_i == CMD_LAST);
        end else if (is_flag_cmd(cmd_i)) begin
          err_d = 1'b1;
        end
        blk_cnt_d  = (blk_cnt_q == IDX_W'(BEATS - 1)) ? '0 : blk_cnt_q + IDX_W'(1);
        byte_cnt_d = byte_cnt_q + LL_W'(BEAT_BYTES);
      end
    end
  end

  assign push_entry = '{data: data_i, idx: blk_cnt_q, first: first_d, last: last_d};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      state_q    <= ST_IDLE;
      cfg_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ll_q       <= '0;
      kk_q       <= '0;
      nn_q       <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      cfg_cnt_q  <= cfg_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ll_q       <= ll_d;
      kk_q       <= kk_d;
      nn_q       <= nn_d;
      err_q      <= err_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  io_skid_fifo #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (nreset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (data_ready_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign data_v_o      = ~fifo_empty;
  assign data_o        = head.data;
  assign data_idx_o    = head.idx;
  assign block_first_o = head.first;
  assign block_last_o  = head.last;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign ll_o          = ll_q;
  assign byte_cnt_o    = byte_cnt_q;
  assign err_o         = err_q;
  assign ready_v_o     = ready_v_i & ~data_v_o;
  assign hash_v_o      = hash_v_i;

  assign echo = {2'b00, mode_q, err_q, cmd_i, valid_i};

  always_comb begin
    case (mode_q)
      LB_NONE: hash_o = hash_i;
      LB_DATA: hash_o = data_i;
      default: hash_o = BEAT_W'(echo);
    endcase
  end

endmodule
